if_stage_ctrl: RTL

- Front end of the 5-stage RISC-V pipeline: the program counter register, next-PC selection and the IF/ID pipeline register.
- Consumer of the load-use hazard signal (if_we: 1 = advance, 0 = stall) produced by the hazard detector.
- Supplies the hazard detector with the register fields it compares (id_rs1, id_rs2).
- Handles jump/branch redirect (flush) and keeps a saturating stall-cycle counter for debug.

---
 rtl/if_stage_ctrl_pkg.sv | 30 +++
 rtl/if_stage_ctrl_if.sv | 36 +++
 rtl/if_stage_ctrl_if_id_reg.sv | 44 ++++
 rtl/if_stage_ctrl.sv | 69 ++++++
 4 files changed

// File: rtl/if_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_ctrl_pkg
// Brief    : Shared constants and next-PC select encoding for the IF stage.
// Revision : 1.0
// ============================================================================
package if_stage_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_ADVANCE  = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // Redirect outranks a stall; a stall outranks advancing.
  function automatic pc_sel_e pc_sel(input logic redirect, input logic if_we);
    if (redirect)   return PC_REDIRECT;
    else if (if_we) return PC_ADVANCE;
    else            return PC_HOLD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_ctrl_if
// Brief    : Hazard, redirect, imem and IF/ID-facing signals of the IF stage.
// Revision : 1.0
// ============================================================================
interface if_stage_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import if_stage_ctrl_pkg::*;

  logic            if_we;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;
  logic [XLEN-1:0] id_instr;
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_we, redirect, redirect_pc, imem_instr,
    input  pc, id_pc, id_pc4, id_instr, id_valid, id_rs1, id_rs2, stall_cnt
  );

  modport slave (
    input  if_we, redirect, redirect_pc, imem_instr,
    output pc, id_pc, id_pc4, id_instr, id_valid, id_rs1, id_rs2, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/if_stage_ctrl_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with enable and synchronous flush.
// Revision : 1.0
// ============================================================================
module if_id_reg
  import if_stage_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_en,
  input  wire logic            i_flush,
  input  wire logic [XLEN-1:0] i_pc,
  input  wire logic [XLEN-1:0] i_instr,
  output logic      [XLEN-1:0] o_pc,
  output logic      [XLEN-1:0] o_instr,
  output logic                 o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_ctrl
// Brief    : PC register, next-PC selection, IF/ID register and stall counter.
// Revision : 1.0
// ============================================================================
module if_stage_ctrl
  import if_stage_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int              CNT_W     = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  if_stage_ctrl_if.slave  bus
);

  pc_sel_e          w_sel;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [XLEN-1:0]  w_id_pc;
  logic [XLEN-1:0]  w_id_instr;
  logic             w_id_valid;

  assign w_sel = pc_sel(bus.redirect, bus.if_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_stall_cnt <= '0;
    end else begin
      case (w_sel)
        PC_REDIRECT: r_pc <= bus.redirect_pc;
        PC_ADVANCE:  r_pc <= r_pc + XLEN'(4);
        default: begin
          if (r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_sel == PC_ADVANCE),
    .i_flush (bus.redirect),
    .i_pc    (r_pc),
    .i_instr (bus.imem_instr),
    .o_pc    (w_id_pc),
    .o_instr (w_id_instr),
    .o_valid (w_id_valid)
  );

  // Decode fields come from the IF/ID register only, keeping the hazard loop registered.
  assign bus.pc        = r_pc;
  assign bus.id_pc     = w_id_pc;
  assign bus.id_pc4    = w_id_pc + XLEN'(4);
  assign bus.id_instr  = w_id_instr;
  assign bus.id_valid  = w_id_valid;
  assign bus.id_rs1    = w_id_instr[RS1_LSB +: 5];
  assign bus.id_rs2    = w_id_instr[RS2_LSB +: 5];
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
